// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// SEQ_TX_PARITY_EN adds one even-parity bit after each frame's pattern bits.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int SEQ_PAT_W = 4;
  localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 4'b1101;

  // Serial length of one frame, including the parity bit when it is enabled.
  function automatic int frame_len(input int pat_w);
`ifdef SEQ_TX_PARITY_EN
    return pat_w + 1;
`else
    return pat_w;
`endif
  endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-first shift register; zeros are shifted in at the LSB.
module seq_tx_shreg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q;

  // Load takes priority over shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end else begin
      sr_q <= sr_q;
    end
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: repeats PATTERN MSB-first rep_count times with gap idle cycles between frames.
// Build option SEQ_TX_PARITY_EN appends an even-parity bit to every frame.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int                 PAT_W   = SEQ_PAT_W,
  parameter logic [PAT_W-1:0]   PATTERN = SEQ_PATTERN,
  parameter int                 CNT_W   = 8,
  parameter int                 GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_count,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             out_valid,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int FRAME_L = frame_len(PAT_W);
  localparam int BIT_W   = $clog2(FRAME_L + 1);
  localparam logic [BIT_W-1:0] LAST_IDX     = BIT_W'(FRAME_L - 1);
  localparam logic [BIT_W-1:0] LAST_PAT_IDX = BIT_W'(PAT_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE      = BIT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE      = GAP_W'(1);
  localparam logic             PAR_BIT      = ^PATTERN;
  // The shift register holds the bits still to come after the one on the line.
  localparam logic [PAT_W-1:0] SR_LOAD      = {PATTERN[PAT_W-2:0], 1'b0};

  state_e           state_q;
  logic [BIT_W-1:0] bit_idx_q;
  logic [CNT_W-1:0] rem_q;
  logic [GAP_W-1:0] gap_len_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             out_q, out_valid_q, frame_q, busy_q, done_q;

  logic last_bit, frame_start, sr_load, sr_shift, sr_msb, next_bit;

  // Frame boundary decisions shared by the FSM and the shift register.
  always_comb begin
    last_bit    = 1'b0;
    frame_start = 1'b0;
    next_bit    = 1'b0;
    if (state_q == ST_SEND) begin
      last_bit = (bit_idx_q == LAST_IDX);
    end else begin
      last_bit = 1'b0;
    end
    if (state_q == ST_IDLE) begin
      frame_start = start && (rep_count != '0);
    end else if (state_q == ST_GAP) begin
      frame_start = (gap_cnt_q == '0);
    end else begin
      frame_start = last_bit && (rem_q != CNT_ONE) && (gap_len_q == '0);
    end
    if (bit_idx_q == LAST_PAT_IDX) begin
      next_bit = PAR_BIT;
    end else begin
      next_bit = sr_msb;
    end
    sr_load  = frame_start;
    sr_shift = (state_q == ST_SEND) && !frame_start;
  end

  seq_tx_shreg #(.W(PAT_W)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (SR_LOAD),
    .msb_o   (sr_msb)
  );

  // Transfer FSM with counters; outputs are registered for the cycle being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      rem_q       <= '0;
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      frame_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rem_q     <= rep_count;
            gap_len_q <= gap;
            bit_idx_q <= '0;
            if (rep_count != '0) begin
              state_q     <= ST_SEND;
              out_q       <= PATTERN[PAT_W-1];
              out_valid_q <= 1'b1;
              frame_q     <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (last_bit) begin
            rem_q     <= rem_q - CNT_ONE;
            bit_idx_q <= '0;
            if (rem_q == CNT_ONE) begin
              state_q     <= ST_DONE;
              out_q       <= 1'b0;
              out_valid_q <= 1'b0;
              frame_q     <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else if (gap_len_q == '0) begin
              out_q   <= PATTERN[PAT_W-1];
              frame_q <= 1'b1;
            end else begin
              state_q     <= ST_GAP;
              gap_cnt_q   <= gap_len_q - GAP_ONE;
              out_q       <= 1'b0;
              out_valid_q <= 1'b0;
              frame_q     <= 1'b0;
            end
          end else begin
            bit_idx_q <= bit_idx_q + BIT_ONE;
            out_q     <= next_bit;
            frame_q   <= 1'b0;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            state_q     <= ST_SEND;
            bit_idx_q   <= '0;
            out_q       <= PATTERN[PAT_W-1];
            out_valid_q <= 1'b1;
            frame_q     <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_ONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          out_q       <= 1'b0;
          out_valid_q <= 1'b0;
          frame_q     <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign frame     = frame_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: expected per-cycle output traces are queued at each accepted
// start and compared by an independent negedge monitor.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rep_count = 8'd0;
  logic [3:0] gap = 4'd0;
  logic       out, out_valid, frame, busy, done;

  typedef struct packed {
    logic o;
    logic v;
    logic f;
    logic b;
    logic d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] pat_v = 4'b1101;

  always #5 clk = ~clk;

  seq_pattern_tx dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rep_count (rep_count),
    .gap       (gap),
    .out       (out),
    .out_valid (out_valid),
    .frame     (frame),
    .busy      (busy),
    .done      (done)
  );

  // Reference: the transfer as a sequence of cycles, starting the cycle after accept.
  task automatic push_run(input int n, input int g);
    exp_t e;
    if (n == 0) begin
      e = '{o: 1'b0, v: 1'b0, f: 1'b0, b: 1'b0, d: 1'b1};
      exp_q.push_back(e);
    end else begin
      for (int f = 0; f < n; f++) begin
        for (int i = 0; i < 4; i++) begin
          e = '{o: pat_v[3-i], v: 1'b1, f: (i == 0), b: 1'b1, d: 1'b0};
          exp_q.push_back(e);
        end
`ifdef SEQ_TX_PARITY_EN
        e = '{o: ^pat_v, v: 1'b1, f: 1'b0, b: 1'b1, d: 1'b0};
        exp_q.push_back(e);
`endif
        if (f < n - 1) begin
          for (int k = 0; k < g; k++) begin
            e = '{o: 1'b0, v: 1'b0, f: 1'b0, b: 1'b1, d: 1'b0};
            exp_q.push_back(e);
          end
        end
      end
      e = '{o: 1'b0, v: 1'b0, f: 1'b0, b: 1'b0, d: 1'b1};
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every cycle pop the expected output, or expect quiet outputs when nothing is pending.
  exp_t act_m, exp_m;
  always @(negedge clk) begin
    act_m = '{o: out, v: out_valid, f: frame, b: busy, d: done};
    if (exp_q.size() > 0) begin
      exp_m = exp_q.pop_front();
    end else begin
      exp_m = '0;
    end
    n_checks++;
    if (act_m !== exp_m) begin
      n_fail++;
      $display("FAIL outputs t=%0t {out,valid,frame,busy,done} got %b required %b",
               $time, act_m, exp_m);
    end
  end

  // Issue one start (called #1 after a posedge) and run through the done cycle,
  // throwing ignored start pulses and scrambled fields at the DUT while it works.
  task automatic run(input int n, input int g, input int start_pct);
    int m;
    start = 1'b1;
    rep_count = 8'(n);
    gap = 4'(g);
    @(posedge clk);
    push_run(n, g);
    m = exp_q.size();
    #1;
    for (int j = 1; j <= m; j++) begin
      start = ($urandom_range(99) < start_pct);
      rep_count = 8'($urandom);
      gap = 4'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run(1, 0, 0);
    run(3, 0, 0);
    run(2, 2, 0);
    run(0, 0, 0);
    run(5, 0, 60);
    run(0, 3, 100);

    // Reset during the third bit of a four-frame run.
    start = 1'b1;
    rep_count = 8'd4;
    gap = 4'd0;
    @(posedge clk);
    push_run(4, 0);
    #1 start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1 rst = 1'b0;
    run(1, 0, 0);

    for (int r = 0; r < 40; r++) begin
      run($urandom_range(5), $urandom_range(4), 25);
      repeat ($urandom_range(2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: on a start request it emits a fixed PAT_W-bit pattern (default 1101) MSB-first on a single-bit serial line, repeated a programmable number of times with a programmable idle gap between frames. It is the stimulus/transmit side for the serial sequence-detector blocks in the design. It also drives link self-test and bring-up streams.

## Interface
- PAT_W, 4, pattern length in bits (≥2)
- PATTERN, 4'b1101, pattern value, transmitted MSB first
- CNT_W, 8, width of repeat counter
- GAP_W, 4, width of inter-frame gap field
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset: synchronous, active-high
- start  in  1  request; sampled only in IDLE
- rep_count  in  CNT_W  number of frames; latched on accepted start
- gap  in  GAP_W  idle cycles between frames; latched on accepted start
- out  out  1  serial data, registered; 0 when out_valid=0
- out_valid  out  1  out carries a pattern (or parity) bit
- frame  out  1  high with the first bit of each frame
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after the last bit of the last frame

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE: outputs low. start=1 → latch rep_count and gap, load shift register with PATTERN, bit counter=0. If rep_count≠0 go SEND; else go DONE.
- SEND: each cycle drive the next bit, MSB first; frame=1 on bit index 0. After the last bit: decrement remaining-frames. If remaining=0 go DONE. Else if gap=0 reload pattern and stay in SEND (back-to-back). Else go GAP.
- GAP: out=0, out_valid=0, busy=1 for exactly `gap` cycles, then reload pattern and go SEND.
- DONE: done=1, busy=0 for one cycle, then IDLE. start is ignored in DONE.
- start while busy is ignored. rep_count/gap changes after acceptance have no effect.
- Counters: bit index 0..PAT_W-1 (PAT_W+1 frame length with parity). Remaining-frames is CNT_W bits; no wrap, since it never decrements below 1 in SEND.

## Timing
- Reset values: out=0, out_valid=0, frame=0, busy=0, done=0, state=IDLE; counters cleared.
- start accepted at edge k → first bit (frame=1) valid in cycle k+1.
- One frame occupies L cycles, where L=PAT_W (or PAT_W+1 with parity).
- Total from accept to done: N·L + (N−1)·gap cycles of busy, then done in the following cycle. Here N=rep_count.
- rep_count=0: busy never asserts; done pulses in cycle k+1.
- rst asserted mid-transfer: at the next edge, all outputs are at reset values, with no done pulse; a new start is accepted the cycle after rst deasserts.

## Configuration
- SEQ_TX_PARITY_EN defined: after the PAT_W pattern bits of each frame, one extra bit is sent with out_valid=1. Its value is even parity (XOR of PATTERN bits), so L=PAT_W+1; for 1101 the parity bit is 1.
- Not defined: no parity bit; L=PAT_W.

## Structure
- Shared package seq_pkg: state enum (IDLE/SEND/GAP/DONE), default PATTERN constant 4'b1101, PAT_W default.
- One sub-module natural: seq_tx_shreg (loadable PAT_W-bit MSB-first shift register with load/shift enables); FSM and counters stay in top.

## Test plan
- rep_count=1, gap=0, start one cycle → out_valid cycles k+1..k+4, out=1,1,0,1, frame only at k+1, done at k+5, busy k+1..k+4.
- rep_count=3, gap=0 → 12 contiguous valid bits 110111011101, frame at bits 0/4/8, one done pulse.
- rep_count=2, gap=2 → bits 1101, two invalid cycles with out=0, then 1101; done 11 cycles after accept.
- rep_count=0 → busy stays 0, done at k+1; start pulses during a rep_count=5 run → ignored, exactly 20 bits sent.
- rst asserted at third bit of a rep_count=4 run → next cycle all outputs 0, no done; start 2 cycles later → fresh frame 1101.
- With SEQ_TX_PARITY_EN, rep_count=2, gap=0 → 1101 1 1101 1 (10 bits), frame at bits 0/5, done at k+11.
